// File: rtl/vx_mem_arb_pkg.sv
// vx_mem_arb_pkg: default local_mem widths, request payload type and width helpers for vx_mem_req_arb
package vx_mem_arb_pkg;
  localparam int MEM_ADDR_WIDTH = 26;
  localparam int MEM_DATA_WIDTH = 512;
  localparam int MEM_TAG_WIDTH = 56;
  function automatic int log_reqs(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int tag_out_width(input int tag_w, input int n);
    return tag_w + log_reqs(n);
  endfunction
  typedef struct packed {
    logic rw;
    logic [MEM_DATA_WIDTH/8-1:0] byteen;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [MEM_TAG_WIDTH:0] tag;
  } mem_req_t;
endpackage

// File: rtl/vx_mem_req_buf.sv
// vx_mem_req_buf: one-entry elastic request register, refills in the same cycle it drains
module vx_mem_req_buf
  import vx_mem_arb_pkg::*;
#(
  parameter type req_t = mem_req_t
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  req_t in_data,
  output logic out_valid,
  input  logic out_ready,
  output req_t out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) out_valid <= 1'b0;
    else if (in_ready) out_valid <= in_valid;
    if (in_valid && in_ready) out_data <= in_data;
  end
endmodule

// File: rtl/vx_mem_req_arb.sv
// vx_mem_req_arb: round-robin sharing of one local_mem port among NUM_REQS requesters; VX_MEM_ARB_PERF_EN adds perf counters
module vx_mem_req_arb
  import vx_mem_arb_pkg::*;
#(
  parameter int NUM_REQS = 2,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH = 56,
  parameter int PERF_WIDTH = 32,
  localparam int LOG_REQS = log_reqs(NUM_REQS),
  localparam int TAG_OUT_WIDTH = tag_out_width(TAG_WIDTH, NUM_REQS),
  localparam int BYTEEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic clk,
  input  logic reset,
`ifdef VX_MEM_ARB_PERF_EN
  output logic [NUM_REQS-1:0][PERF_WIDTH-1:0] perf_grants,
  output logic [PERF_WIDTH-1:0] perf_stalls,
`endif
  input  logic [NUM_REQS-1:0] in_req_valid,
  input  logic [NUM_REQS-1:0] in_req_rw,
  input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0] in_req_byteen,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0] in_req_addr,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0] in_req_data,
  input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] in_req_tag,
  output logic [NUM_REQS-1:0] in_req_ready,
  output logic [NUM_REQS-1:0] in_rsp_valid,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0] in_rsp_data,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0] in_rsp_tag,
  input  logic [NUM_REQS-1:0] in_rsp_ready,
  output logic mem_req_valid,
  output logic mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0] mem_req_tag,
  input  logic mem_req_ready,
  input  logic mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0] mem_rsp_tag,
  output logic mem_rsp_ready
);
  typedef struct packed {
    logic rw;
    logic [BYTEEN_WIDTH-1:0] byteen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_t;
  if (NUM_REQS < 2 || PERF_WIDTH < 1) begin : g_bad_cfg
    $error("vx_mem_req_arb: NUM_REQS must be >= 2 and PERF_WIDTH >= 1");
  end
  logic [LOG_REQS-1:0] rr_ptr, winner, rsp_id;
  logic can_load, load;
  req_t buf_in, buf_out;
  always_comb begin
    winner = rr_ptr;
    for (int k = NUM_REQS - 1; k >= 0; k--)
      if (in_req_valid[(int'(rr_ptr) + k) % NUM_REQS]) winner = LOG_REQS'((int'(rr_ptr) + k) % NUM_REQS);
  end
  assign load = |in_req_valid && can_load && !reset;
  assign in_req_ready = load ? NUM_REQS'(1) << winner : '0;
  assign buf_in = '{
    rw: in_req_rw[winner],
    byteen: in_req_byteen[winner],
    addr: in_req_addr[winner],
    data: in_req_data[winner],
    tag: {in_req_tag[winner], winner}
  };
  always_ff @(posedge clk)
    if (reset) rr_ptr <= '0;
    else if (load) rr_ptr <= (int'(winner) == NUM_REQS - 1) ? '0 : winner + 1'b1;
  vx_mem_req_buf #(.req_t(req_t)) req_buf (
    .clk(clk),
    .reset(reset),
    .in_valid(load),
    .in_ready(can_load),
    .in_data(buf_in),
    .out_valid(mem_req_valid),
    .out_ready(mem_req_ready),
    .out_data(buf_out)
  );
  assign mem_req_rw = buf_out.rw;
  assign mem_req_byteen = buf_out.byteen;
  assign mem_req_addr = buf_out.addr;
  assign mem_req_data = buf_out.data;
  assign mem_req_tag = buf_out.tag;
  assign rsp_id = mem_rsp_tag[LOG_REQS-1:0];
  assign in_rsp_valid = mem_rsp_valid ? NUM_REQS'(1) << rsp_id : '0;
  assign in_rsp_data = {NUM_REQS{mem_rsp_data}};
  assign in_rsp_tag = {NUM_REQS{mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_REQS]}};
  assign mem_rsp_ready = (int'(rsp_id) < NUM_REQS) ? in_rsp_ready[rsp_id] : 1'b1;
`ifdef VX_MEM_ARB_PERF_EN
  always_ff @(posedge clk)
    if (reset) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++)
        if (in_req_ready[i] && !(&perf_grants[i])) perf_grants[i] <= perf_grants[i] + 1'b1;
      if (mem_req_valid && !mem_req_ready && !(&perf_stalls)) perf_stalls <= perf_stalls + 1'b1;
    end
`endif
endmodule

// File: tb/tb_vx_mem_req_arb.sv
// tb_vx_mem_req_arb: scoreboard bench for vx_mem_req_arb with 2- and 3-requester instances
module tb_vx_mem_req_arb;
  localparam int AW = 26, DW = 32, TW = 8;
  typedef logic [72:0] pk_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  pk_t qa[$], qb[$];
  logic [1:0] a_valid, a_rw, a_ready, a_rsp_valid, a_rsp_ready;
  logic [1:0][3:0] a_be;
  logic [1:0][AW-1:0] a_addr;
  logic [1:0][DW-1:0] a_data, a_rsp_data;
  logic [1:0][TW-1:0] a_tag, a_rsp_tag;
  logic am_valid, am_rw, am_ready, am_rsp_valid, am_rsp_ready;
  logic [3:0] am_be;
  logic [AW-1:0] am_addr;
  logic [DW-1:0] am_data, am_rsp_data;
  logic [TW:0] am_tag, am_rsp_tag;
  logic [2:0] b_valid, b_rw, b_ready, b_rsp_valid, b_rsp_ready;
  logic [2:0][3:0] b_be;
  logic [2:0][AW-1:0] b_addr;
  logic [2:0][DW-1:0] b_data, b_rsp_data;
  logic [2:0][TW-1:0] b_tag, b_rsp_tag;
  logic bm_valid, bm_rw, bm_ready, bm_rsp_valid, bm_rsp_ready;
  logic [3:0] bm_be;
  logic [AW-1:0] bm_addr;
  logic [DW-1:0] bm_data, bm_rsp_data;
  logic [TW+1:0] bm_tag, bm_rsp_tag;
`ifdef VX_MEM_ARB_PERF_EN
  logic [1:0][31:0] a_perf_grants;
  logic [31:0] a_perf_stalls;
  logic [2:0][31:0] b_perf_grants;
  logic [31:0] b_perf_stalls;
`endif
  vx_mem_req_arb #(.NUM_REQS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut_a (
    .clk(clk), .reset(reset),
`ifdef VX_MEM_ARB_PERF_EN
    .perf_grants(a_perf_grants), .perf_stalls(a_perf_stalls),
`endif
    .in_req_valid(a_valid), .in_req_rw(a_rw), .in_req_byteen(a_be), .in_req_addr(a_addr),
    .in_req_data(a_data), .in_req_tag(a_tag), .in_req_ready(a_ready),
    .in_rsp_valid(a_rsp_valid), .in_rsp_data(a_rsp_data), .in_rsp_tag(a_rsp_tag), .in_rsp_ready(a_rsp_ready),
    .mem_req_valid(am_valid), .mem_req_rw(am_rw), .mem_req_byteen(am_be), .mem_req_addr(am_addr),
    .mem_req_data(am_data), .mem_req_tag(am_tag), .mem_req_ready(am_ready),
    .mem_rsp_valid(am_rsp_valid), .mem_rsp_data(am_rsp_data), .mem_rsp_tag(am_rsp_tag), .mem_rsp_ready(am_rsp_ready)
  );
  vx_mem_req_arb #(.NUM_REQS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut_b (
    .clk(clk), .reset(reset),
`ifdef VX_MEM_ARB_PERF_EN
    .perf_grants(b_perf_grants), .perf_stalls(b_perf_stalls),
`endif
    .in_req_valid(b_valid), .in_req_rw(b_rw), .in_req_byteen(b_be), .in_req_addr(b_addr),
    .in_req_data(b_data), .in_req_tag(b_tag), .in_req_ready(b_ready),
    .in_rsp_valid(b_rsp_valid), .in_rsp_data(b_rsp_data), .in_rsp_tag(b_rsp_tag), .in_rsp_ready(b_rsp_ready),
    .mem_req_valid(bm_valid), .mem_req_rw(bm_rw), .mem_req_byteen(bm_be), .mem_req_addr(bm_addr),
    .mem_req_data(bm_data), .mem_req_tag(bm_tag), .mem_req_ready(bm_ready),
    .mem_rsp_valid(bm_rsp_valid), .mem_rsp_data(bm_rsp_data), .mem_rsp_tag(bm_rsp_tag), .mem_rsp_ready(bm_rsp_ready)
  );
  function automatic pk_t pk(logic rw, logic [3:0] be, logic [AW-1:0] a, logic [DW-1:0] d, logic [9:0] t);
    return {rw, be, a, d, t};
  endfunction
  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_a(input int i, input logic rw, input logic [3:0] be, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [TW-1:0] t);
    a_valid[i] = 1'b1; a_rw[i] = rw; a_be[i] = be; a_addr[i] = ad; a_data[i] = d; a_tag[i] = t;
  endtask
  task automatic set_b(input int i, input int k);
    b_valid[i] = 1'b1; b_rw[i] = i[0]; b_be[i] = 4'(k + 3); b_addr[i] = AW'(512 + k * 4 + i);
    b_data[i] = DW'(32'hB000_0000 + k * 16 + i); b_tag[i] = TW'(8'h40 + k * 4 + i);
  endtask
  always @(negedge clk)
    if (!reset && am_valid && am_ready) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_req: got %0h, want none", am_addr);
      end else check("a_mem_req", pk(am_rw, am_be, am_addr, am_data, {1'b0, am_tag}), qa.pop_front());
    end
  always @(negedge clk)
    if (!reset && bm_valid && bm_ready) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_req: got %0h, want none", bm_addr);
      end else check("b_mem_req", pk(bm_rw, bm_be, bm_addr, bm_data, bm_tag), qb.pop_front());
    end
  initial begin
    a_valid = '0; a_rw = '0; a_be = '0; a_addr = '0; a_data = '0; a_tag = '0; a_rsp_ready = 2'b11;
    am_ready = 1'b1; am_rsp_valid = 1'b0; am_rsp_data = '0; am_rsp_tag = '0;
    b_valid = '0; b_rw = '0; b_be = '0; b_addr = '0; b_data = '0; b_tag = '0; b_rsp_ready = 3'b111;
    bm_ready = 1'b1; bm_rsp_valid = 1'b0; bm_rsp_data = '0; bm_rsp_tag = '0;
    a_valid = 2'b11;
    tick();
    tick();
    check("rst_mem_valid", 73'(am_valid), 0);
    check("rst_in_ready", 73'(a_ready), 0);
    // T1: single read from requester 0 and its response
    reset = 1'b0; a_valid = '0;
    set_a(0, 1'b0, 4'hF, 26'h10, 32'hCAFE_0000, 8'h05);
    #1;
    check("t1_ready", 73'(a_ready), 2'b01);
    qa.push_back(pk(1'b0, 4'hF, 26'h10, 32'hCAFE_0000, {1'b0, 8'h05, 1'b0}));
    tick();
    a_valid = '0;
    check("t1_mem_valid", 73'(am_valid), 1);
    tick();
    check("t1_drained", 73'(am_valid), 0);
    am_rsp_valid = 1'b1; am_rsp_tag = {8'h05, 1'b0}; am_rsp_data = 32'h1234_5678;
    #1;
    check("t1_rsp_valid", 73'(a_rsp_valid), 2'b01);
    check("t1_rsp_tag", 73'(a_rsp_tag[0]), 8'h05);
    check("t1_rsp_data", 73'(a_rsp_data[0]), 32'h1234_5678);
    check("t1_rsp_ready", 73'(am_rsp_ready), 1);
    am_rsp_valid = 1'b0;
    // T2: both requesters every cycle; pointer sits at 1 after T1
    for (int k = 0; k < 6; k++) begin
      int w;
      w = (k % 2 == 0) ? 1 : 0;
      for (int i = 0; i < 2; i++)
        set_a(i, ((k + i) % 2) == 1, 4'(k + i + 1), AW'(256 + k * 4 + i), DW'(32'hD000_0000 + k * 16 + i), TW'(8'h20 + k * 2 + i));
      #1;
      check("t2_grant", 73'(a_ready), 73'(1 << w));
      if (k > 0) check("t2_mem_valid", 73'(am_valid), 1);
      qa.push_back(pk(((k + w) % 2) == 1, 4'(k + w + 1), AW'(256 + k * 4 + w), DW'(32'hD000_0000 + k * 16 + w),
                      {1'b0, TW'(8'h20 + k * 2 + w), w[0]}));
      tick();
    end
    a_valid = '0;
    check("t2_last_valid", 73'(am_valid), 1);
    tick();
    check("t2_drained", 73'(am_valid), 0);
    // T3: backpressure holds the buffered request stable
    am_ready = 1'b0;
    set_a(1, 1'b1, 4'hA, 26'h3A, 32'hBEEF_0001, 8'h77);
    #1;
    check("t3_grant", 73'(a_ready), 2'b10);
    qa.push_back(pk(1'b1, 4'hA, 26'h3A, 32'hBEEF_0001, {1'b0, 8'h77, 1'b1}));
    tick();
    a_valid = '0;
    set_a(0, 1'b0, 4'h5, 26'h3B, 32'hBEEF_0002, 8'h78);
    for (int j = 0; j < 5; j++) begin
      #1;
      check("t3_stall_ready", 73'(a_ready), 0);
      check("t3_stall_payload", {am_valid, am_addr, am_data}, {1'b1, 26'h3A, 32'hBEEF_0001});
      tick();
    end
`ifdef VX_MEM_ARB_PERF_EN
    check("t3_perf_stalls", 73'(a_perf_stalls), 5);
`endif
    am_ready = 1'b1;
    #1;
    check("t3_refill_grant", 73'(a_ready), 2'b01);
    qa.push_back(pk(1'b0, 4'h5, 26'h3B, 32'hBEEF_0002, {1'b0, 8'h78, 1'b0}));
    tick();
    a_valid = '0;
    check("t3_refill_addr", {am_valid, am_addr}, {1'b1, 26'h3B});
    tick();
    check("t3_drained", 73'(am_valid), 0);
    // T4: response for requester 1 waits for its ready
    am_rsp_valid = 1'b1; am_rsp_tag = {8'h33, 1'b1}; a_rsp_ready = 2'b01;
    #1;
    check("t4_rsp_valid", 73'(a_rsp_valid), 2'b10);
    check("t4_rsp_ready_low", 73'(am_rsp_ready), 0);
    check("t4_rsp_tag", 73'(a_rsp_tag[1]), 8'h33);
    a_rsp_ready = 2'b11;
    #1;
    check("t4_rsp_ready_high", 73'(am_rsp_ready), 1);
    am_rsp_valid = 1'b0;
    // T5: reset with a full buffer drops it and returns the pointer to 0
    am_ready = 1'b0;
    set_a(0, 1'b1, 4'h1, 26'h55, 32'h5555_0000, 8'h99);
    #1;
    check("t5_grant", 73'(a_ready), 2'b01);
    tick();
    a_valid = '0;
    check("t5_full", 73'(am_valid), 1);
    reset = 1'b1; a_valid = 2'b11;
    #1;
    check("t5_rst_ready", 73'(a_ready), 0);
    tick();
    check("t5_rst_valid", 73'(am_valid), 0);
    reset = 1'b0; am_ready = 1'b1;
    set_a(0, 1'b0, 4'h2, 26'h60, 32'h6000_0000, 8'h10);
    set_a(1, 1'b1, 4'h3, 26'h61, 32'h6000_0001, 8'h11);
    #1;
    check("t5_tie_grant", 73'(a_ready), 2'b01);
    qa.push_back(pk(1'b0, 4'h2, 26'h60, 32'h6000_0000, {1'b0, 8'h10, 1'b0}));
    tick();
    a_valid = '0;
    tick();
    check("t5_drained", 73'(am_valid), 0);
    // T6: three requesters, 0 and 2 contending
    for (int k = 0; k < 4; k++) begin
      int w;
      w = (k % 2 == 0) ? 0 : 2;
      set_b(0, k);
      set_b(2, k);
      #1;
      check("t6_grant", 73'(b_ready), 73'(1 << w));
      qb.push_back(pk(w == 2 ? 1'b0 : 1'b0, 4'(k + 3), AW'(512 + k * 4 + w), DW'(32'hB000_0000 + k * 16 + w),
                      {TW'(8'h40 + k * 4 + w), 2'(w)}));
      tick();
    end
    b_valid = '0;
    tick();
    check("t6_drained", 73'(bm_valid), 0);
    bm_rsp_valid = 1'b1; bm_rsp_tag = {8'h44, 2'b11};
    #1;
    check("t6_bad_id_valid", 73'(b_rsp_valid), 0);
    check("t6_bad_id_ready", 73'(bm_rsp_ready), 1);
    bm_rsp_tag = {8'h44, 2'b10}; b_rsp_ready = 3'b011;
    #1;
    check("t6_rsp_valid", 73'(b_rsp_valid), 3'b100);
    check("t6_rsp_ready", 73'(bm_rsp_ready), 0);
    check("t6_rsp_tag", 73'(b_rsp_tag[2]), 8'h44);
    bm_rsp_valid = 1'b0;
    tick();
    check("qa_empty", 73'(qa.size()), 0);
    check("qb_empty", 73'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
